// File: rtl/writeback_top.sv
// writeback_top: final RV32I stage. Holds the MEM/WB stage register, commits
// results into the 32x32 integer register file, serves decode with two
// bypassed read ports plus a WB forwarding port, records the first memory
// exception and keeps the cycle / instret counters.
//
// Flow control: wb_stall is a plain hold with no valid/ready pairing. While it
// is high the stage register, register file, exception record and instret all
// keep their values. csr_cycle keeps counting, and the read bypass and
// forwarding outputs keep reflecting the held stage contents.
module writeback_top #(
    parameter int CNT_W  = 64,
    parameter bit RF_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ma_pc,
    input  logic [31:0]      ma_inst,
    input  logic [31:0]      ma_dat,
    input  logic             ma_exc_mis,
    input  logic             ma_exc_oob,
    input  logic             wb_stall,
    input  logic [4:0]       id_rs1_add,
    input  logic [4:0]       id_rs2_add,
    output logic [31:0]      id_rs1_dat,
    output logic [31:0]      id_rs2_dat,
    output logic             id_fwd_we,
    output logic [4:0]       id_fwd_dst,
    output logic [31:0]      id_fwd_dat,
    input  logic             exc_clr,
    output logic             exc_vld,
    output logic [1:0]       exc_cause,
    output logic [31:0]      exc_pc,
    output logic [CNT_W-1:0] csr_cycle,
    output logic [CNT_W-1:0] csr_instret
);

    localparam logic [31:0] BUBBLE    = 32'h0000_0013;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    // Stage register. The pc is not captured here: nothing downstream of this
    // stage consumes it, and the exception record samples ma_pc directly.
    logic [31:0] inst_q;
    logic [31:0] dat_q;

    // x0 has no storage; reads of address 0 are forced to zero below.
    logic [31:0] rf [1:31];

    logic [4:0] rd;
    logic [6:0] opcode;
    logic       we_q;
    logic       retire;
    logic       new_exc;

    assign rd      = inst_q[11:7];
    assign opcode  = inst_q[6:0];
    assign retire  = (inst_q != BUBBLE);
    assign new_exc = ma_exc_mis | ma_exc_oob;

    // Write enable of the instruction sitting in the stage register.
    always_comb begin
        we_q = 1'b0;
        if (retire && (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != 5'd0)) begin
            we_q = 1'b1;
        end
    end

    // MEM/WB stage register: capture whenever not stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q <= BUBBLE;
            dat_q  <= 32'd0;
        end else if (!wb_stall) begin
            inst_q <= ma_inst;
            dat_q  <= ma_dat;
        end
    end

    // Register-file commit; reset optionally clears x1..x31 and always drops the in-flight write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RF_RST) begin
                for (int i = 1; i < 32; i++) begin
                    rf[i] <= 32'd0;
                end
            end
        end else if (!wb_stall && we_q) begin
            rf[rd] <= dat_q;
        end
    end

    // Decode read ports with write-through bypass from the stage register.
    always_comb begin
        id_rs1_dat = 32'd0;
        id_rs2_dat = 32'd0;
        if (id_rs1_add != 5'd0) begin
            id_rs1_dat = (we_q && (id_rs1_add == rd)) ? dat_q : rf[id_rs1_add];
        end
        if (id_rs2_add != 5'd0) begin
            id_rs2_dat = (we_q && (id_rs2_add == rd)) ? dat_q : rf[id_rs2_add];
        end
    end

    assign id_fwd_we  = we_q;
    assign id_fwd_dst = rd;
    assign id_fwd_dat = dat_q;

    // Exception record: first exception sticks until cleared; a clear in the
    // same cycle as a new exception lets the new one in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_vld   <= 1'b0;
            exc_cause <= 2'b00;
            exc_pc    <= 32'd0;
        end else if (!wb_stall) begin
            if ((!exc_vld || exc_clr) && new_exc) begin
                exc_vld   <= 1'b1;
                exc_cause <= {ma_exc_oob, ma_exc_mis};
                exc_pc    <= ma_pc;
            end else if (exc_clr) begin
                exc_vld   <= 1'b0;
                exc_cause <= 2'b00;
                exc_pc    <= 32'd0;
            end
        end
    end

    // Cycle and retired-instruction counters, both wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_cycle   <= '0;
            csr_instret <= '0;
        end else begin
            csr_cycle <= csr_cycle + CNT_W'(1);
            if (!wb_stall && retire) begin
                csr_instret <= csr_instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_top.sv
// tb_writeback_top: directed, table-driven bench for writeback_top.
module tb_writeback_top;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] ma_pc;
    logic [31:0] ma_inst;
    logic [31:0] ma_dat;
    logic        ma_exc_mis;
    logic        ma_exc_oob;
    logic        wb_stall;
    logic [4:0]  id_rs1_add;
    logic [4:0]  id_rs2_add;
    logic [31:0] id_rs1_dat;
    logic [31:0] id_rs2_dat;
    logic        id_fwd_we;
    logic [4:0]  id_fwd_dst;
    logic [31:0] id_fwd_dat;
    logic        exc_clr;
    logic        exc_vld;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [63:0] csr_cycle;
    logic [63:0] csr_instret;

    writeback_top dut (
        .clk(clk), .rst_n(rst_n),
        .ma_pc(ma_pc), .ma_inst(ma_inst), .ma_dat(ma_dat),
        .ma_exc_mis(ma_exc_mis), .ma_exc_oob(ma_exc_oob),
        .wb_stall(wb_stall),
        .id_rs1_add(id_rs1_add), .id_rs2_add(id_rs2_add),
        .id_rs1_dat(id_rs1_dat), .id_rs2_dat(id_rs2_dat),
        .id_fwd_we(id_fwd_we), .id_fwd_dst(id_fwd_dst), .id_fwd_dat(id_fwd_dat),
        .exc_clr(exc_clr), .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .csr_cycle(csr_cycle), .csr_instret(csr_instret)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Small reference model of the counters and the stage instruction.
    logic [31:0] m_inst;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;

    // Scoreboard queue for the final register-file sweep.
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] dat;
        logic [4:0]  add;
        logic        fwd_we;
        logic [4:0]  fwd_dst;
        logic [31:0] rd_n1;
        logic [31:0] rd_n2;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, updating the model from the inputs applied before the edge.
    task automatic step();
        if (!rst_n) begin
            m_inst = BUBBLE;
            m_cyc  = 64'd0;
            m_ret  = 64'd0;
        end else begin
            m_cyc++;
            if (!wb_stall) begin
                if (m_inst != BUBBLE) m_ret++;
                m_inst = ma_inst;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ma(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] dat,
                            input logic mis, input logic oob);
        ma_pc      = pc;
        ma_inst    = inst;
        ma_dat     = dat;
        ma_exc_mis = mis;
        ma_exc_oob = oob;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cycle"}, csr_cycle, m_cyc);
        check({tag, "_instret"}, csr_instret, m_ret);
    endtask

    task automatic check_exc(input string tag, input logic vld, input logic [1:0] cause, input logic [31:0] pc);
        check({tag, "_vld"}, {63'd0, exc_vld}, {63'd0, vld});
        check({tag, "_cause"}, {62'd0, exc_cause}, {62'd0, cause});
        check({tag, "_pc"}, {32'd0, exc_pc}, {32'd0, pc});
    endtask

    initial begin
        // inst, dat, read add, fwd_we, fwd_dst, read in N+1, read in N+2
        vecs[0] = '{32'h00A0_0293, 32'h0000_000A, 5'd5,  1'b1, 5'd5,  32'h0000_000A, 32'h0000_000A}; // addi x5
        vecs[1] = '{32'h0020_8033, 32'hFFFF_FFFF, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0};         // add x0
        vecs[2] = '{32'h0051_2023, 32'h1234_5678, 5'd5,  1'b0, 5'd0,  32'h0000_000A, 32'h0000_000A}; // sw
        vecs[3] = '{32'h0020_8463, 32'h0000_DEAD, 5'd8,  1'b0, 5'd8,  32'h0,         32'h0};         // beq
        vecs[4] = '{32'hABCD_EFB7, 32'hABCD_E000, 5'd31, 1'b1, 5'd31, 32'hABCD_E000, 32'hABCD_E000}; // lui x31
        vecs[5] = '{32'h0012_8293, 32'h0000_000B, 5'd5,  1'b1, 5'd5,  32'h0000_000B, 32'h0000_000B}; // addi x5 again
        vecs[6] = '{BUBBLE,        32'h0000_0055, 5'd31, 1'b0, 5'd0,  32'hABCD_E000, 32'hABCD_E000}; // bubble

        // Reset block: two cycles low
        rst_n      = 1'b0;
        wb_stall   = 1'b0;
        exc_clr    = 1'b0;
        id_rs1_add = 5'd0;
        id_rs2_add = 5'd0;
        drive_ma(32'd0, BUBBLE, 32'd0, 1'b0, 1'b0);
        step();
        step();
        check_exc("reset", 1'b0, 2'b00, 32'd0);
        check_counters("reset");
        check("reset_fwd_we", {63'd0, id_fwd_we}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            id_rs1_add = 5'(a);
            id_rs2_add = 5'(31 - a);
            #1;
            check("reset_rs1", {32'd0, id_rs1_dat}, 64'd0);
            check("reset_rs2", {32'd0, id_rs2_dat}, 64'd0);
        end
        rst_n = 1'b1;

        // Table-driven single-instruction vectors
        for (int i = 0; i < 7; i++) begin
            drive_ma(32'h100 + 32'(i * 4), vecs[i].inst, vecs[i].dat, 1'b0, 1'b0);
            id_rs1_add = vecs[i].add;
            id_rs2_add = vecs[i].add;
            step();
            check($sformatf("v%0d_fwd_we", i), {63'd0, id_fwd_we}, {63'd0, vecs[i].fwd_we});
            check($sformatf("v%0d_fwd_dst", i), {59'd0, id_fwd_dst}, {59'd0, vecs[i].fwd_dst});
            check($sformatf("v%0d_fwd_dat", i), {32'd0, id_fwd_dat}, {32'd0, vecs[i].dat});
            check($sformatf("v%0d_rs1_n1", i), {32'd0, id_rs1_dat}, {32'd0, vecs[i].rd_n1});
            check($sformatf("v%0d_rs2_n1", i), {32'd0, id_rs2_dat}, {32'd0, vecs[i].rd_n1});
            drive_ma(32'h0, BUBBLE, 32'h0, 1'b0, 1'b0);
            step();
            check($sformatf("v%0d_rs1_n2", i), {32'd0, id_rs1_dat}, {32'd0, vecs[i].rd_n2});
            check($sformatf("v%0d_rs2_n2", i), {32'd0, id_rs2_dat}, {32'd0, vecs[i].rd_n2});
            check_counters($sformatf("v%0d", i));
        end

        // Stall: stage holds addi x6, bypass stays live, exceptions and clears ignored
        drive_ma(32'h200, 32'h0770_0313, 32'h0000_0077, 1'b0, 1'b0);
        id_rs1_add = 5'd6;
        id_rs2_add = 5'd5;
        step();
        check("stall_pre_dst", {59'd0, id_fwd_dst}, 64'd6);
        wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_ma(32'h300 + 32'(k), 32'h0010_0393, 32'h90 + 32'(k), 1'b1, 1'b0);
            exc_clr = 1'b1;
            step();
            check("stall_fwd_dst", {59'd0, id_fwd_dst}, 64'd6);
            check("stall_fwd_dat", {32'd0, id_fwd_dat}, 64'h77);
            check("stall_bypass", {32'd0, id_rs1_dat}, 64'h77);
            check("stall_instret", csr_instret, m_ret);
        end
        check("stall_cycle", csr_cycle, m_cyc);
        check("stall_exc_vld", {63'd0, exc_vld}, 64'd0);
        wb_stall = 1'b0;
        exc_clr  = 1'b0;
        drive_ma(32'h400, 32'h0010_0393, 32'h0000_0099, 1'b0, 1'b0);
        step();
        check("release_dst", {59'd0, id_fwd_dst}, 64'd7);
        check("release_dat", {32'd0, id_fwd_dat}, 64'h99);
        check("release_x6_rf", {32'd0, id_rs1_dat}, 64'h77);
        check_counters("release");

        // Exception record sequence
        drive_ma(32'h40, BUBBLE, 32'h0, 1'b1, 1'b0);
        step();
        check_exc("exc_mis", 1'b1, 2'b01, 32'h40);
        drive_ma(32'h44, BUBBLE, 32'h0, 1'b0, 1'b1);
        step();
        check_exc("exc_hold", 1'b1, 2'b01, 32'h40);
        drive_ma(32'h48, BUBBLE, 32'h0, 1'b0, 1'b1);
        exc_clr = 1'b1;
        step();
        check_exc("exc_clr_new", 1'b1, 2'b10, 32'h48);
        drive_ma(32'h4C, BUBBLE, 32'h0, 1'b0, 1'b0);
        step();
        check_exc("exc_clr", 1'b0, 2'b00, 32'h0);
        exc_clr = 1'b0;
        drive_ma(32'h50, BUBBLE, 32'h0, 1'b1, 1'b1);
        step();
        check_exc("exc_both", 1'b1, 2'b11, 32'h50);
        drive_ma(32'h54, BUBBLE, 32'h0, 1'b0, 1'b0);
        wb_stall = 1'b1;
        exc_clr  = 1'b1;
        step();
        check_exc("exc_clr_stalled", 1'b1, 2'b11, 32'h50);
        wb_stall = 1'b0;
        step();
        check_exc("exc_clr_late", 1'b0, 2'b00, 32'h0);
        exc_clr = 1'b0;

        // Register-file sweep against the scoreboard queue
        exp_q.push_back(32'h0000_000B);
        exp_q.push_back(32'h0000_0077);
        exp_q.push_back(32'h0000_0099);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hABCD_E000);
        foreach (vecs[j]) begin
            if (j < 5) begin
                logic [4:0] addrs [5];
                logic [31:0] exp_v;
                addrs = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd31};
                id_rs1_add = addrs[j];
                #1;
                exp_v = exp_q.pop_front();
                check($sformatf("rf_x%0d", addrs[j]), {32'd0, id_rs1_dat}, {32'd0, exp_v});
            end
        end

        // Reset mid-operation: in-flight addi x9 is discarded
        drive_ma(32'h500, 32'h0000_0493, 32'h0000_1234, 1'b0, 1'b0);
        step();
        check("midrst_fwd_we", {63'd0, id_fwd_we}, 64'd1);
        rst_n = 1'b0;
        drive_ma(32'h0, BUBBLE, 32'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        id_rs1_add = 5'd9;
        id_rs2_add = 5'd5;
        #1;
        check("midrst_x9", {32'd0, id_rs1_dat}, 64'd0);
        check("midrst_x5", {32'd0, id_rs2_dat}, 64'd0);
        check_counters("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
